// File: rtl/lc3_execute_pipe.sv
// LC-3 execute stage: operand bypass, ALU, address adder and the
// execute/memory pipeline register with stall, flush and async reset.
module lc3_execute_pipe #(
    parameter int DATA_W  = 16,
    parameter int NUM_BYP = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable_execute,
    input  logic                        flush,
    input  logic [5:0]                  E_control,
    input  logic [15:0]                 IR,
    input  logic [DATA_W-1:0]           npc_in,
    input  logic [DATA_W-1:0]           VSR1,
    input  logic [DATA_W-1:0]           VSR2,
    input  logic [$clog2(NUM_BYP+2)-1:0] byp_sel_1,
    input  logic [$clog2(NUM_BYP+2)-1:0] byp_sel_2,
    input  logic [NUM_BYP*DATA_W-1:0]   Mem_Bypass_Val,
    input  logic                        Mem_Control_in,
    input  logic [1:0]                  W_Control_in,
    output logic [DATA_W-1:0]           aluout,
    output logic [DATA_W-1:0]           pcout,
    output logic [DATA_W-1:0]           M_Data,
    output logic [15:0]                 IR_Exec,
    output logic [2:0]                  dr,
    output logic [2:0]                  nzp,
    output logic                        Mem_Control_out,
    output logic [1:0]                  W_Control_out,
    output logic                        ex_valid,
    output logic [2:0]                  sr1,
    output logic [2:0]                  sr2
);

    localparam int SEL_W = $clog2(NUM_BYP + 2);

    logic [1:0] alu_op;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_bv;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] addr;
    logic [2:0]        nzp_res;

    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [DATA_W-1:0] pcout_q, pcout_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [15:0]       ir_q, ir_d;
    logic [2:0]        dr_q, dr_d;
    logic [2:0]        nzp_q, nzp_d;
    logic              mc_q, mc_d;
    logic [1:0]        wc_q, wc_d;
    logic              valid_q, valid_d;

    assign alu_op = E_control[5:4];
    assign pcsel1 = E_control[3:2];
    assign pcsel2 = E_control[1];
    assign op2sel = E_control[0];

    // Unmatched select codes (including out-of-range ones) fall back to the VSR.
    function automatic logic [DATA_W-1:0] pick(
        input logic [SEL_W-1:0]          sel,
        input logic [DATA_W-1:0]         vsr,
        input logic [DATA_W-1:0]         self_val,
        input logic [NUM_BYP*DATA_W-1:0] byp
    );
        logic [DATA_W-1:0] r;
        r = vsr;
        if (sel == SEL_W'(1)) r = self_val;
        for (int k = 0; k < NUM_BYP; k++) begin
            if (sel == SEL_W'(k + 2)) r = byp[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    always_comb begin
        op_a  = pick(byp_sel_1, VSR1, aluout_q, Mem_Bypass_Val);
        op_bv = pick(byp_sel_2, VSR2, aluout_q, Mem_Bypass_Val);
        op_b  = op2sel ? op_bv : {{(DATA_W-5){IR[4]}}, IR[4:0]};
    end

    always_comb begin
        alu_res = op_a;
        unique case (alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a & op_b;
            2'b10: alu_res = ~op_a;
            2'b11: alu_res = op_a;
        endcase
    end

    always_comb begin
        offset = '0;
        unique case (pcsel1)
            2'b00: offset = {{(DATA_W-11){IR[10]}}, IR[10:0]};
            2'b01: offset = {{(DATA_W-9){IR[8]}}, IR[8:0]};
            2'b10: offset = {{(DATA_W-6){IR[5]}}, IR[5:0]};
            2'b11: offset = '0;
        endcase
        base = pcsel2 ? npc_in : op_a;
        addr = offset + base;
    end

    always_comb begin
        if (alu_res[DATA_W-1]) nzp_res = 3'b100;
        else if (alu_res == '0) nzp_res = 3'b010;
        else nzp_res = 3'b001;
    end

    always_comb begin
        aluout_d = aluout_q;
        pcout_d  = pcout_q;
        mdata_d  = mdata_q;
        ir_d     = ir_q;
        dr_d     = dr_q;
        nzp_d    = nzp_q;
        mc_d     = mc_q;
        wc_d     = wc_q;
        valid_d  = valid_q;
        if (enable_execute) begin
            if (flush) begin
                // A killed slot keeps its data but must not commit downstream.
                mc_d    = 1'b0;
                wc_d    = 2'b00;
                valid_d = 1'b0;
            end else begin
                aluout_d = alu_res;
                pcout_d  = addr;
                mdata_d  = op_bv;
                ir_d     = IR;
                dr_d     = IR[11:9];
                nzp_d    = nzp_res;
                mc_d     = Mem_Control_in;
                wc_d     = W_Control_in;
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout_q <= '0;
            pcout_q  <= '0;
            mdata_q  <= '0;
            ir_q     <= '0;
            dr_q     <= '0;
            nzp_q    <= '0;
            mc_q     <= 1'b0;
            wc_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            mdata_q  <= mdata_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            nzp_q    <= nzp_d;
            mc_q     <= mc_d;
            wc_q     <= wc_d;
            valid_q  <= valid_d;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign M_Data          = mdata_q;
    assign IR_Exec         = ir_q;
    assign dr              = dr_q;
    assign nzp             = nzp_q;
    assign Mem_Control_out = mc_q;
    assign W_Control_out   = wc_q;
    assign ex_valid        = valid_q;
    assign sr1             = IR[8:6];
    assign sr2             = IR[2:0];

endmodule

// File: tb/tb_lc3_execute_pipe.sv
// Bench for lc3_execute_pipe: directed scenarios plus random traffic
// checked against an arithmetic reference model.
module tb_lc3_execute_pipe;

    logic        clock;
    logic        reset;
    logic        en;
    logic        flush;
    logic [5:0]  ec;
    logic [15:0] ir;
    logic [15:0] npc, vsr1, vsr2;
    logic [1:0]  bs1, bs2;
    logic [31:0] byp;
    logic        mci;
    logic [1:0]  wci;

    logic [15:0] aluout, pcout, mdata, irx;
    logic [2:0]  dr, nzp, sr1, sr2;
    logic        mco, exv;
    logic [1:0]  wco;

    logic [31:0] npc32, v1_32, v2_32, byp32;
    logic [1:0]  s1_32, s2_32;
    logic [31:0] alu32, pc32, md32;
    logic [15:0] irx32;
    logic [2:0]  dr32, nzp32, sr1_32, sr2_32;
    logic        mco32, exv32;
    logic [1:0]  wco32;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_alu, m_pc, m_md, m_ir;
    logic [2:0]  m_dr, m_nzp;
    logic        m_mc, m_v;
    logic [1:0]  m_wc;

    logic [15:0] e_alu, e_pc, e_md;
    logic [2:0]  e_nzp;

    lc3_execute_pipe dut (
        .clock(clock), .reset(reset), .enable_execute(en), .flush(flush),
        .E_control(ec), .IR(ir), .npc_in(npc), .VSR1(vsr1), .VSR2(vsr2),
        .byp_sel_1(bs1), .byp_sel_2(bs2), .Mem_Bypass_Val(byp),
        .Mem_Control_in(mci), .W_Control_in(wci),
        .aluout(aluout), .pcout(pcout), .M_Data(mdata), .IR_Exec(irx),
        .dr(dr), .nzp(nzp), .Mem_Control_out(mco), .W_Control_out(wco),
        .ex_valid(exv), .sr1(sr1), .sr2(sr2)
    );

    lc3_execute_pipe #(.DATA_W(32), .NUM_BYP(1)) dut32 (
        .clock(clock), .reset(reset), .enable_execute(en), .flush(flush),
        .E_control(ec), .IR(ir), .npc_in(npc32), .VSR1(v1_32), .VSR2(v2_32),
        .byp_sel_1(s1_32), .byp_sel_2(s2_32), .Mem_Bypass_Val(byp32),
        .Mem_Control_in(mci), .W_Control_in(wci),
        .aluout(alu32), .pcout(pc32), .M_Data(md32), .IR_Exec(irx32),
        .dr(dr32), .nzp(nzp32), .Mem_Control_out(mco32), .W_Control_out(wco32),
        .ex_valid(exv32), .sr1(sr1_32), .sr2(sr2_32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    function automatic logic [15:0] src(input logic [1:0] sel, input logic [15:0] vsr);
        case (sel)
            2'd0:    return vsr;
            2'd1:    return m_alu;
            2'd2:    return byp[15:0];
            default: return byp[31:16];
        endcase
    endfunction

    task automatic predict();
        logic [15:0] a, b;
        int off;
        a    = src(bs1, vsr1);
        e_md = src(bs2, vsr2);
        b    = ec[0] ? e_md : 16'(sx(int'(ir[4:0]), 5));
        case (ec[5:4])
            2'd0:    e_alu = 16'(int'(a) + int'(b));
            2'd1:    e_alu = a & b;
            2'd2:    e_alu = 16'(65535 - int'(a));
            default: e_alu = a;
        endcase
        case (ec[3:2])
            2'd0:    off = sx(int'(ir[10:0]), 11);
            2'd1:    off = sx(int'(ir[8:0]), 9);
            2'd2:    off = sx(int'(ir[5:0]), 6);
            default: off = 0;
        endcase
        e_pc  = 16'(int'(ec[1] ? npc : a) + off);
        e_nzp = (e_alu >= 16'h8000) ? 3'b100 : (e_alu == 16'h0) ? 3'b010 : 3'b001;
    endtask

    task automatic model_reset();
        m_alu = '0; m_pc = '0; m_md = '0; m_ir = '0;
        m_dr = '0; m_nzp = '0; m_mc = 1'b0; m_wc = '0; m_v = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".aluout"}, 32'(aluout), 32'(m_alu));
        chk({tag, ".pcout"}, 32'(pcout), 32'(m_pc));
        chk({tag, ".mdata"}, 32'(mdata), 32'(m_md));
        chk({tag, ".ir_exec"}, 32'(irx), 32'(m_ir));
        chk({tag, ".dr"}, 32'(dr), 32'(m_dr));
        chk({tag, ".nzp"}, 32'(nzp), 32'(m_nzp));
        chk({tag, ".mctl"}, 32'(mco), 32'(m_mc));
        chk({tag, ".wctl"}, 32'(wco), 32'(m_wc));
        chk({tag, ".valid"}, 32'(exv), 32'(m_v));
        chk({tag, ".sr1"}, 32'(sr1), 32'(ir[8:6]));
        chk({tag, ".sr2"}, 32'(sr2), 32'(ir[2:0]));
    endtask

    task automatic tick(input string tag);
        predict();
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else if (en) begin
            if (flush) begin
                m_v = 1'b0; m_mc = 1'b0; m_wc = '0;
            end else begin
                m_alu = e_alu; m_pc = e_pc; m_md = e_md; m_ir = ir;
                m_dr = ir[11:9]; m_nzp = e_nzp; m_mc = mci; m_wc = wci; m_v = 1'b1;
            end
        end
        check_all(tag);
    endtask

    task automatic clear_inputs();
        en = 1'b0; flush = 1'b0; ec = '0; ir = '0; npc = '0;
        vsr1 = '0; vsr2 = '0; bs1 = '0; bs2 = '0; byp = '0;
        mci = 1'b0; wci = '0;
        npc32 = '0; v1_32 = '0; v2_32 = '0; byp32 = '0; s1_32 = '0; s2_32 = '0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_all("reset_async");
        chk("reset_async.alu32", alu32, 32'h0);
        en = 1'b1; mci = 1'b1; wci = 2'b11; vsr1 = 16'h7777;
        tick("reset_held");
        @(negedge clock);
        reset = 1'b0;

        vsr1 = 16'h0005; vsr2 = 16'h0003; ec = 6'b000001;
        v1_32 = 32'h5; v2_32 = 32'h3; mci = 1'b0; wci = 2'b01;
        tick("add_reg");
        chk("add_reg.lit_alu", 32'(aluout), 32'h0008);
        chk("add_reg.lit_nzp", 32'(nzp), 32'(3'b001));
        chk("add_reg.lit_valid", 32'(exv), 32'h1);
        chk("add_reg.alu32", alu32, 32'h0000_0008);

        vsr1 = 16'hFFFF; ir = 16'h0001; ec = 6'b000000;
        tick("wrap_add");
        chk("wrap_add.lit_alu", 32'(aluout), 32'h0000);
        chk("wrap_add.lit_nzp", 32'(nzp), 32'(3'b010));
        ec = 6'b100000; bs1 = 2'd1; vsr1 = 16'h1111;
        tick("not_self");
        chk("not_self.lit_alu", 32'(aluout), 32'hFFFF);
        chk("not_self.lit_nzp", 32'(nzp), 32'(3'b100));

        bs1 = 2'd0; npc = 16'h3001; ir = 16'h01FE; ec = 6'b000110;
        tick("addr");
        chk("addr.lit_pcout", 32'(pcout), 32'h2FFF);

        ir = 16'h0000; vsr1 = 16'h00FF; byp = {16'h1234, 16'h5555};
        bs2 = 2'd3; ec = 6'b010001; mci = 1'b1; wci = 2'b10;
        tick("membyp");
        chk("membyp.lit_alu", 32'(aluout), 32'h0034);
        chk("membyp.lit_mdata", 32'(mdata), 32'h1234);

        flush = 1'b1; vsr1 = 16'hABCD; wci = 2'b11;
        tick("flush");
        chk("flush.lit_alu", 32'(aluout), 32'h0034);
        chk("flush.lit_valid", 32'(exv), 32'h0);
        chk("flush.lit_wctl", 32'(wco), 32'h0);

        for (int i = 0; i < 3; i++) begin
            en = 1'b0; flush = 1'(i % 2); vsr1 = 16'($urandom); ir = 16'($urandom);
            ec = 6'($urandom); mci = 1'b1;
            tick("stall");
        end
        chk("stall.lit_alu", 32'(aluout), 32'h0034);

        en = 1'b1; flush = 1'b0; ec = 6'b000001; ir = 16'h0000;
        s1_32 = 2'd3; s2_32 = 2'd2; v1_32 = 32'h1000_0000;
        v2_32 = 32'h0000_0999; byp32 = 32'h0000_0022;
        tick("oor");
        chk("oor.alu32", alu32, 32'h1000_0022);
        chk("oor.mdata32", md32, 32'h0000_0022);
        s1_32 = 2'd0; s2_32 = 2'd0;

        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 7) == 0);
            ec    = 6'($urandom);
            ir    = 16'($urandom);
            npc   = 16'($urandom);
            vsr1  = 16'($urandom);
            vsr2  = 16'($urandom);
            bs1   = 2'($urandom);
            bs2   = 2'($urandom);
            byp   = $urandom;
            mci   = 1'($urandom);
            wci   = 2'($urandom);
            tick("rand");
        end

        en = 1'b1; flush = 1'b0; mci = 1'b1; wci = 2'b11; ec = 6'b000001;
        tick("pre_reset");
        @(negedge clock);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid");
        chk("reset_mid.alu32", alu32, 32'h0);
        chk("reset_mid.valid32", 32'(exv32), 32'h0);
        tick("reset_mid_edge");
        @(negedge clock);
        reset = 1'b0;

        clear_inputs();
        en = 1'b1; vsr1 = 16'h0005; vsr2 = 16'h0003; ec = 6'b000001;
        v1_32 = 32'h5; v2_32 = 32'h3;
        tick("post_reset");
        chk("post_reset.lit_alu", 32'(aluout), 32'h0008);
        chk("post_reset.alu32", alu32, 32'h0000_0008);
        chk("post_reset.nzp32", 32'(nzp32), 32'(3'b001));
        chk("post_reset.valid32", 32'(exv32), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
